// File: rtl/vga_pkg.sv
// Shared VGA constants: resolution-derived sizes and drawing-engine state codes.
// Purely combinational/constant content; no latency.
// No flow control; consumed at elaboration time by vga_adapter users.
package vga_pkg;

    // Drawing-engine FSM encoding (shared with other engines driving the adapter)
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DRAW = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Resolution strings are all 7 characters, so a 56-bit vector holds any of them.
    // Unknown strings fall back to 640x480.
    function automatic int res_xmax(input logic [55:0] res);
        if (res == "320x240")      return 320;
        else if (res == "160x120") return 160;
        else                       return 640;
    endfunction

    function automatic int res_ymax(input logic [55:0] res);
        if (res == "320x240")      return 240;
        else if (res == "160x120") return 120;
        else                       return 480;
    endfunction

    function automatic int res_nx(input logic [55:0] res);
        if (res == "320x240")      return 9;
        else if (res == "160x120") return 8;
        else                       return 10;
    endfunction

    function automatic int res_ny(input logic [55:0] res);
        if (res == "320x240")      return 8;
        else if (res == "160x120") return 7;
        else                       return 9;
    endfunction

endpackage

// File: rtl/vga_xy_scan.sv
// Row-major x/y scan counter over [x0,xe) x [y0,ye); bounds captured on load.
// Latency: counters valid the cycle after load; advance one step per enabled cycle.
// No backpressure: deasserting enable simply holds position; counters hold at the last pixel.
// Ports: clock/resetn; load + x0/y0/xe/ye capture a new region; enable steps;
//        x/y current position; last flags the final pixel of the region.
module vga_xy_scan #(
    parameter int NX = 10,
    parameter int NY = 9
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          load,
    input  logic [NX-1:0] x0,
    input  logic [NY-1:0] y0,
    input  logic [NX:0]   xe,
    input  logic [NY:0]   ye,
    input  logic          enable,
    output logic [NX-1:0] x,
    output logic [NY-1:0] y,
    output logic          last
);

    logic [NX-1:0] x0_q;
    logic [NX:0]   xe_q;
    logic [NY:0]   ye_q;
    logic          row_end;

    // Compare in the wider end-point width so xe == 2**NX is reachable.
    assign row_end = (({1'b0, x} + 1'b1) == xe_q);
    assign last    = row_end && (({1'b0, y} + 1'b1) == ye_q);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x    <= '0;
            y    <= '0;
            x0_q <= '0;
            xe_q <= '0;
            ye_q <= '0;
        end else if (load) begin
            x    <= x0;
            y    <= y0;
            x0_q <= x0;
            xe_q <= xe;
            ye_q <= ye;
        end else if (enable && !last) begin
            // At the final pixel we hold, so x/y keep their last values afterwards.
            if (row_end) begin
                x <= x0_q;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine for the vga_adapter pixel-write port, one pixel per clock.
// Latency: first write the cycle after start is accepted; done one cycle after the last write.
// No backpressure: writes are unconditional; start is only sampled in IDLE and never queued.
// Ports: clock/resetn; start with x0/y0/w/h/fill_color requests a fill;
//        x/y/color/write drive the adapter; busy while drawing; done pulses on completion.
module vga_rect_fill
    import vga_pkg::*;
#(
    parameter logic [55:0] RESOLUTION  = "640x480",
    parameter int          COLOR_DEPTH = 9,
    parameter int          nX          = res_nx(RESOLUTION),
    parameter int          nY          = res_ny(RESOLUTION)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [nX-1:0]          x0,
    input  logic [nY-1:0]          y0,
    input  logic [nX:0]            w,
    input  logic [nY:0]            h,
    input  logic [COLOR_DEPTH-1:0] fill_color,
    output logic [nX-1:0]          x,
    output logic [nY-1:0]          y,
    output logic [COLOR_DEPTH-1:0] color,
    output logic                   write,
    output logic                   busy,
    output logic                   done
);

    localparam int XMAX_I = res_xmax(RESOLUTION);
    localparam int YMAX_I = res_ymax(RESOLUTION);
    // One guard bit beyond the end-point width so x0+w can never wrap.
    localparam logic [nX+1:0] XMAX = XMAX_I[nX+1:0];
    localparam logic [nY+1:0] YMAX = YMAX_I[nY+1:0];

    logic [1:0]             state;
    logic [COLOR_DEPTH-1:0] color_q;
    logic [nX+1:0]          x_sum;
    logic [nY+1:0]          y_sum;
    logic [nX:0]            xe;
    logic [nY:0]            ye;
    logic                   empty;
    logic                   accept;
    logic                   load;
    logic                   scan_last;

    assign x_sum = {2'b00, x0} + {1'b0, w};
    assign y_sum = {2'b00, y0} + {1'b0, h};
    // The clamped value is at most XMAX/YMAX, which fits the end-point width.
    assign xe    = (x_sum > XMAX) ? XMAX[nX:0] : x_sum[nX:0];
    assign ye    = (y_sum > YMAX) ? YMAX[nY:0] : y_sum[nY:0];

    assign empty  = ({2'b00, x0} >= XMAX) || ({2'b00, y0} >= YMAX) ||
                    (w == '0) || (h == '0);
    assign accept = (state == IDLE) && start;
    assign load   = accept && !empty;

    vga_xy_scan #(
        .NX (nX),
        .NY (nY)
    ) u_scan (
        .clock  (clock),
        .resetn (resetn),
        .load   (load),
        .x0     (x0),
        .y0     (y0),
        .xe     (xe),
        .ye     (ye),
        .enable (state == DRAW),
        .x      (x),
        .y      (y),
        .last   (scan_last)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            color_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= empty ? DONE : DRAW;
                    end
                    // Colour only changes for a real fill so it holds while write=0.
                    if (load) begin
                        color_q <= fill_color;
                    end
                end
                DRAW: begin
                    if (scan_last) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded straight from the state register so reset clears them without a clock edge.
    assign write = (state == DRAW);
    assign busy  = (state == DRAW);
    assign done  = (state == DONE);
    assign color = color_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed self-checking bench for vga_rect_fill at 160x120, 9-bit colour.
module tb_vga_rect_fill;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [8:0] w;
    logic [7:0] h;
    logic [8:0] fill_color;
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] color;
    logic       write;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    vga_rect_fill #(
        .RESOLUTION  ("160x120"),
        .COLOR_DEPTH (9)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .w          (w),
        .h          (h),
        .fill_color (fill_color),
        .x          (x),
        .y          (y),
        .color      (color),
        .write      (write),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_fill(input int xs, input int ys, input int ww, input int hh,
                              input int cc, input bit hold);
        x0         = xs[7:0];
        y0         = ys[6:0];
        w          = ww[8:0];
        h          = hh[7:0];
        fill_color = cc[8:0];
        start      = 1'b1;
        tick();
        if (!hold) start = 1'b0;
    endtask

    // Expects writes over [xs,xe) x [ys,ye) in row-major order, then one done cycle,
    // then an idle cycle. poke >= 0 pulses start with other operands at that pixel.
    task automatic check_fill(input int xs, input int ys, input int xe, input int ye,
                              input int cc, input int poke);
        int n = 0;
        for (int yy = ys; yy < ye; yy++) begin
            for (int xx = xs; xx < xe; xx++) begin
                chk("write", {31'd0, write}, 32'd1);
                chk("busy",  {31'd0, busy},  32'd1);
                chk("done",  {31'd0, done},  32'd0);
                chk("x",     {24'd0, x},     xx);
                chk("y",     {25'd0, y},     yy);
                chk("color", {23'd0, color}, cc);
                if (n == poke) begin
                    start = 1'b1; x0 = 8'd1; y0 = 7'd1; w = 9'd50; h = 8'd50;
                    fill_color = 9'h03F;
                end
                tick();
                if (n == poke) start = 1'b0;
                n++;
            end
        end
        chk("done_pulse", {31'd0, done},  32'd1);
        chk("done_write", {31'd0, write}, 32'd0);
        chk("done_busy",  {31'd0, busy},  32'd0);
        tick();
        chk("idle_done",  {31'd0, done},  32'd0);
        chk("idle_write", {31'd0, write}, 32'd0);
        chk("idle_busy",  {31'd0, busy},  32'd0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; x0 = '0; y0 = '0; w = '0; h = '0; fill_color = '0;
        #12;
        chk("rst_x",     {24'd0, x},     32'd0);
        chk("rst_y",     {25'd0, y},     32'd0);
        chk("rst_color", {23'd0, color}, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_done",  {31'd0, done},  32'd0);
        @(negedge clock);
        resetn = 1'b1;
        tick();
        chk("idle_after_rst", {31'd0, write}, 32'd0);

        // Basic 4x3 fill at (10,5)
        start_fill(10, 5, 4, 3, 'h1C0, 1'b0);
        check_fill(10, 5, 14, 8, 'h1C0, -1);

        // Zero width: done the cycle after start, x/y/color hold the previous fill
        start_fill(3, 3, 0, 7, 'h0AA, 1'b0);
        check_fill(3, 3, 3, 3, 'h1C0, -1);
        chk("hold_x",     {24'd0, x},     32'd13);
        chk("hold_y",     {25'd0, y},     32'd7);
        chk("hold_color", {23'd0, color}, 32'h1C0);

        // x0 beyond the right edge
        start_fill(200, 10, 5, 5, 'h0AA, 1'b0);
        check_fill(0, 0, 0, 0, 'h1C0, -1);

        // Clipping at the bottom-right corner
        start_fill(158, 118, 5, 5, 'h155, 1'b0);
        check_fill(158, 118, 160, 120, 'h155, -1);

        // Mid-fill start with other operands is ignored
        start_fill(40, 20, 3, 2, 'h00F, 1'b0);
        check_fill(40, 20, 43, 22, 'h00F, 2);

        // start held high re-triggers after the idle cycle following done
        start_fill(60, 60, 2, 2, 'h123, 1'b1);
        check_fill(60, 60, 62, 62, 'h123, -1);
        tick();
        start = 1'b0;
        check_fill(60, 60, 62, 62, 'h123, -1);

        // Asynchronous reset during the 3rd pixel of a 4x3 fill
        start_fill(20, 30, 4, 3, 'h0F0, 1'b0);
        chk("pre_rst_x0", {24'd0, x}, 32'd20);
        tick();
        chk("pre_rst_x1", {24'd0, x}, 32'd21);
        tick();
        chk("pre_rst_x2", {24'd0, x}, 32'd22);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_write", {31'd0, write}, 32'd0);
        chk("arst_busy",  {31'd0, busy},  32'd0);
        chk("arst_done",  {31'd0, done},  32'd0);
        chk("arst_x",     {24'd0, x},     32'd0);
        chk("arst_y",     {25'd0, y},     32'd0);
        tick();
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_write", {31'd0, write}, 32'd0);
            chk("post_rst_done",  {31'd0, done},  32'd0);
        end

        // Full-screen clear
        start_fill(0, 0, 160, 120, 'h1FF, 1'b0);
        check_fill(0, 0, 160, 120, 'h1FF, -1);
        chk("clear_last_x", {24'd0, x}, 32'd159);
        chk("clear_last_y", {25'd0, y}, 32'd119);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_rect_fill.md
Name: vga_rect_fill

Overview:
Drawing engine that drives the pixel-write port (x, y, color, write) of vga_adapter. It fills an axis-aligned rectangle with one colour, writing one pixel per clock in row-major order. Rectangles are clipped to the active resolution. A start/busy/done handshake lets a controller FSM (demo code, CPU display peripheral) issue fills and screen clears on top of the MIF background.

Parameters:
RESOLUTION, "640x480", one of "640x480", "320x240", "160x120"; must match vga_adapter and the DESim GUI
COLOR_DEPTH, 9, colour bits per pixel: 9, 6 or 3
nX, derived 10/9/8, X coordinate width for RESOLUTION
nY, derived 9/8/7, Y coordinate width for RESOLUTION

Ports:
clock  in  1  system clock (CLOCK_50)
resetn  in  1  asynchronous active-low reset (KEY[0])
start  in  1  request a fill; sampled only in IDLE
x0  in  nX  left column of rectangle
y0  in  nY  top row of rectangle
w  in  nX+1  width in pixels (0 is legal)
h  in  nY+1  height in pixels (0 is legal)
fill_color  in  COLOR_DEPTH  fill colour
x  out  nX  pixel column to vga_adapter.x
y  out  nY  pixel row to vga_adapter.y
color  out  COLOR_DEPTH  to vga_adapter.color
write  out  1  pixel write strobe to vga_adapter.write
busy  out  1  fill in progress
done  out  1  one-cycle pulse when a fill completes

Behaviour:
- Interface: single clock domain on clock. resetn is asynchronous, active-low, and is the only reset.
- Reset (async, any time including mid-fill): state IDLE; x=0, y=0, color=0, write=0, busy=0, done=0. A partially drawn rectangle is abandoned and no further writes occur.
- XMAX/YMAX are 640/480, 320/240 or 160/120, selected by RESOLUTION.
- States: IDLE, DRAW, DONE.
- IDLE: when start=1 at a clock edge, latch x0, y0 and fill_color.
  - Compute clipped end points xe = min(x0+w, XMAX) and ye = min(y0+h, YMAX) in nX+1 and nY+1 bit arithmetic. No wrap is allowed.
  - If x0>=XMAX, y0>=YMAX, w=0 or h=0, the rectangle is empty: go to DONE. No write is issued.
  - Otherwise go to DRAW with the counters at (x0,y0).
- DRAW: each cycle, write=1 with x/y equal to the counters and color equal to the latched colour. busy=1.
  - Advance x. When x+1==xe, reset x to x0 and advance y.
  - At the final pixel (x==xe-1, y==ye-1), go to DONE.
- DONE: exactly one cycle. done=1, write=0, busy=0. Then return to IDLE.
- Latency: start at edge N gives the first write in the cycle after edge N. The write count equals (xe-x0)*(ye-y0) on consecutive cycles with no gaps. done is asserted the cycle after the last write.
- busy is 1 only in DRAW.
- start is ignored in DRAW and DONE; it is not queued. start held high re-triggers a new fill from the IDLE cycle after DONE.
- Input operands may change freely after the start cycle without affecting the fill in progress.
- When write=0, x/y/color hold their last values. The adapter ignores them.
- The block never emits x>=XMAX or y>=YMAX.

Decomposition:
- Shared package vga_pkg:
  - resolution-to-XMAX/YMAX and resolution-to-nX/nY constant functions
  - state encoding localparams (IDLE/DRAW/DONE)
  - these are shared with vga_adapter users
- One sub-module is natural: vga_xy_scan, a row-major x/y counter.
  - inputs: load, x0, y0, xe, ye, enable
  - outputs: x, y, last
  - it is reusable for a future copy/blit engine.
- The FSM, clipping and output registers stay in vga_rect_fill.

Test Plan:
- 160x120, 9-bit: x0=10, y0=5, w=4, h=3, fill_color=9'h1C0 -> 12 consecutive writes. Order is (10,5)..(13,5), (10,6)..(13,6), (10,7)..(13,7), all colour 9'h1C0. done pulses the cycle after (13,7). busy is high for exactly 12 cycles.
- w=0, h=7 (and separately x0=200 at 160x120) -> zero write cycles. done pulses one cycle after start. busy stays 0.
- Clipping at 160x120: x0=158, y0=118, w=5, h=5 -> exactly 4 writes, (158,118), (159,118), (158,119), (159,119), then done. No coordinate is >=160 or >=120.
- start pulsed again mid-fill with different operands -> ignored. The original fill completes unchanged. With start held high, a second fill begins the cycle after done.
- resetn dropped asynchronously during the 3rd pixel of a 4x3 fill -> write, busy and done go to 0 immediately, without waiting for a clock edge. After release the FSM is in IDLE and no writes occur until the next start.
- Full clear at 160x120: x0=0, y0=0, w=160, h=120 -> 19200 consecutive writes. The last write is (159,119), followed by a single done pulse.
